// File: rtl/lsu_pkg.sv
// Shared constants for the load/store stage: one-hot access-type bit indices,
// misalignment trap causes and the request FSM state type.
package lsu_pkg;

  localparam int LB_IDX  = 0;
  localparam int LH_IDX  = 1;
  localparam int LW_IDX  = 2;
  localparam int LBU_IDX = 3;
  localparam int LHU_IDX = 4;

  localparam int SB_IDX = 0;
  localparam int SH_IDX = 1;
  localparam int SW_IDX = 2;

  localparam logic [31:0] LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] STORE_MISALIGN = 32'd6;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the one-hot load type.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          addr_lo,
  input  logic [4:0]          load_sign,
  output logic [DATA_LEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*addr_lo +: 8];
  assign half_sel = rdata[16*addr_lo[1] +: 16];

  always_comb begin
    load_data = rdata;
    if (load_sign[LB_IDX]) begin
      load_data = {{(DATA_LEN-8){byte_sel[7]}}, byte_sel};
    end else if (load_sign[LH_IDX]) begin
      load_data = {{(DATA_LEN-16){half_sel[15]}}, half_sel};
    end else if (load_sign[LBU_IDX]) begin
      load_data = {{(DATA_LEN-8){1'b0}}, byte_sel};
    end else if (load_sign[LHU_IDX]) begin
      load_data = {{(DATA_LEN-16){1'b0}}, half_sel};
    end
  end

endmodule

// File: rtl/lsu.sv
// RV32 load/store stage: issues one data-memory request per memory entry,
// waits for its response and registers the result into the LS_WB stage.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_LS_reg_execute_valid,
  input  logic [DATA_LEN-1:0]   EX_LS_reg_dest_data,
  input  logic [DATA_LEN-1:0]   EX_LS_reg_addr_load,
  input  logic [DATA_LEN-1:0]   EX_LS_reg_store_data,
  input  logic [4:0]            EX_LS_reg_rd,
  input  logic [4:0]            EX_LS_reg_load_sign,
  input  logic [3:0]            EX_LS_reg_store_sign,
  input  logic [DATA_LEN-1:0]   EX_LS_reg_csr_wdata,
  input  logic [DATA_LEN-1:0]   EX_LS_reg_cause,
  input  logic [1:0]            EX_LS_reg_csr_wfunc,
  input  logic [11:0]           EX_LS_reg_CSR_addr,
  input  logic                  EX_LS_reg_unusual_flag,
  input  logic                  EX_LS_reg_ebreak,
  input  logic                  EX_LS_reg_CSR_ren,
  input  logic                  EX_LS_reg_CSR_wen,
  input  logic                  EX_LS_reg_dest_wen,
  output logic                  EX_reg_execute_enable,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_LEN-1:0]   mem_addr,
  output logic                  mem_wen,
  output logic [DATA_LEN-1:0]   mem_wdata,
  output logic [DATA_LEN/8-1:0] mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_LEN-1:0]   mem_rdata,
  output logic                  LS_WB_reg_valid,
  output logic [4:0]            LS_WB_reg_rd,
  output logic [DATA_LEN-1:0]   LS_WB_reg_dest_data,
  output logic                  LS_WB_reg_dest_wen,
  output logic [DATA_LEN-1:0]   LS_WB_reg_csr_wdata,
  output logic [1:0]            LS_WB_reg_csr_wfunc,
  output logic [11:0]           LS_WB_reg_CSR_addr,
  output logic                  LS_WB_reg_CSR_ren,
  output logic                  LS_WB_reg_CSR_wen,
  output logic                  LS_WB_reg_ebreak,
  output logic                  LS_WB_reg_unusual_flag,
  output logic [DATA_LEN-1:0]   LS_WB_reg_cause
);

  localparam int MASK_LEN = DATA_LEN / 8;

  lsu_state_t state, state_next;

  logic [1:0]          addr_lo;
  logic                is_load, is_store, mem_op;
  logic                mis_load, mis_store, misaligned, issue;
  logic [DATA_LEN-1:0] load_data;
  logic                unused_store_sign;

  assign addr_lo           = EX_LS_reg_addr_load[1:0];
  assign unused_store_sign = EX_LS_reg_store_sign[3];

  assign is_load  = |EX_LS_reg_load_sign;
  assign is_store = |EX_LS_reg_store_sign[2:0];
  assign mem_op   = EX_LS_reg_execute_valid & (is_load | is_store);

  assign mis_load  = ((EX_LS_reg_load_sign[LH_IDX] | EX_LS_reg_load_sign[LHU_IDX]) & addr_lo[0])
                   | (EX_LS_reg_load_sign[LW_IDX] & (addr_lo != 2'b00));
  assign mis_store = (EX_LS_reg_store_sign[SH_IDX] & addr_lo[0])
                   | (EX_LS_reg_store_sign[SW_IDX] & (addr_lo != 2'b00));
  assign misaligned = mem_op & (mis_load | mis_store);
  assign issue      = mem_op & ~misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The request is held in IDLE until accepted; execute is stalled for the
  // whole transaction so the EX_LS fields stay stable underneath it.
  always_comb begin
    state_next            = state;
    mem_req_valid         = 1'b0;
    EX_reg_execute_enable = 1'b0;
    case (state)
      IDLE: begin
        mem_req_valid         = issue;
        EX_reg_execute_enable = ~issue;
        if (issue && mem_req_ready) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        EX_reg_execute_enable = mem_rsp_valid;
        if (mem_rsp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr = {EX_LS_reg_addr_load[DATA_LEN-1:2], 2'b00};
  assign mem_wen  = is_store;

  always_comb begin
    mem_wdata = EX_LS_reg_store_data;
    mem_wmask = '0;
    if (EX_LS_reg_store_sign[SW_IDX]) begin
      mem_wmask = {MASK_LEN{1'b1}};
    end else if (EX_LS_reg_store_sign[SH_IDX]) begin
      mem_wdata = {2{EX_LS_reg_store_data[15:0]}};
      mem_wmask = 4'b0011 << {addr_lo[1], 1'b0};
    end else if (EX_LS_reg_store_sign[SB_IDX]) begin
      mem_wdata = {4{EX_LS_reg_store_data[7:0]}};
      mem_wmask = 4'b0001 << addr_lo;
    end
  end

  lsu_load_ext #(
    .DATA_LEN (DATA_LEN)
  ) u_load_ext (
    .rdata     (mem_rdata),
    .addr_lo   (addr_lo),
    .load_sign (EX_LS_reg_load_sign),
    .load_data (load_data)
  );

  // Misaligned entries trap instead of writing back: the cause is overridden
  // and the register write is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LS_WB_reg_valid        <= 1'b0;
      LS_WB_reg_rd           <= '0;
      LS_WB_reg_dest_data    <= '0;
      LS_WB_reg_dest_wen     <= 1'b0;
      LS_WB_reg_csr_wdata    <= '0;
      LS_WB_reg_csr_wfunc    <= '0;
      LS_WB_reg_CSR_addr     <= '0;
      LS_WB_reg_CSR_ren      <= 1'b0;
      LS_WB_reg_CSR_wen      <= 1'b0;
      LS_WB_reg_ebreak       <= 1'b0;
      LS_WB_reg_unusual_flag <= 1'b0;
      LS_WB_reg_cause        <= '0;
    end else if (EX_reg_execute_enable) begin
      LS_WB_reg_valid        <= EX_LS_reg_execute_valid;
      LS_WB_reg_rd           <= EX_LS_reg_rd;
      LS_WB_reg_dest_data    <= (issue && is_load) ? load_data : EX_LS_reg_dest_data;
      LS_WB_reg_dest_wen     <= misaligned ? 1'b0 : EX_LS_reg_dest_wen;
      LS_WB_reg_csr_wdata    <= EX_LS_reg_csr_wdata;
      LS_WB_reg_csr_wfunc    <= EX_LS_reg_csr_wfunc;
      LS_WB_reg_CSR_addr     <= EX_LS_reg_CSR_addr;
      LS_WB_reg_CSR_ren      <= EX_LS_reg_CSR_ren;
      LS_WB_reg_CSR_wen      <= EX_LS_reg_CSR_wen;
      LS_WB_reg_ebreak       <= EX_LS_reg_ebreak;
      LS_WB_reg_unusual_flag <= misaligned ? 1'b1 : EX_LS_reg_unusual_flag;
      LS_WB_reg_cause        <= misaligned ? (mis_load ? LOAD_MISALIGN : STORE_MISALIGN)
                                           : EX_LS_reg_cause;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store stage with a transaction-level reference
// model compared against the DUT on every falling clock edge.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        EX_LS_reg_execute_valid;
  logic [31:0] EX_LS_reg_dest_data;
  logic [31:0] EX_LS_reg_addr_load;
  logic [31:0] EX_LS_reg_store_data;
  logic [4:0]  EX_LS_reg_rd;
  logic [4:0]  EX_LS_reg_load_sign;
  logic [3:0]  EX_LS_reg_store_sign;
  logic [31:0] EX_LS_reg_csr_wdata;
  logic [31:0] EX_LS_reg_cause;
  logic [1:0]  EX_LS_reg_csr_wfunc;
  logic [11:0] EX_LS_reg_CSR_addr;
  logic        EX_LS_reg_unusual_flag;
  logic        EX_LS_reg_ebreak;
  logic        EX_LS_reg_CSR_ren;
  logic        EX_LS_reg_CSR_wen;
  logic        EX_LS_reg_dest_wen;
  logic        EX_reg_execute_enable;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        LS_WB_reg_valid;
  logic [4:0]  LS_WB_reg_rd;
  logic [31:0] LS_WB_reg_dest_data;
  logic        LS_WB_reg_dest_wen;
  logic [31:0] LS_WB_reg_csr_wdata;
  logic [1:0]  LS_WB_reg_csr_wfunc;
  logic [11:0] LS_WB_reg_CSR_addr;
  logic        LS_WB_reg_CSR_ren;
  logic        LS_WB_reg_CSR_wen;
  logic        LS_WB_reg_ebreak;
  logic        LS_WB_reg_unusual_flag;
  logic [31:0] LS_WB_reg_cause;

  int checks   = 0;
  int failures = 0;

  lsu #(.DATA_LEN(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .EX_LS_reg_execute_valid (EX_LS_reg_execute_valid),
    .EX_LS_reg_dest_data     (EX_LS_reg_dest_data),
    .EX_LS_reg_addr_load     (EX_LS_reg_addr_load),
    .EX_LS_reg_store_data    (EX_LS_reg_store_data),
    .EX_LS_reg_rd            (EX_LS_reg_rd),
    .EX_LS_reg_load_sign     (EX_LS_reg_load_sign),
    .EX_LS_reg_store_sign    (EX_LS_reg_store_sign),
    .EX_LS_reg_csr_wdata     (EX_LS_reg_csr_wdata),
    .EX_LS_reg_cause         (EX_LS_reg_cause),
    .EX_LS_reg_csr_wfunc     (EX_LS_reg_csr_wfunc),
    .EX_LS_reg_CSR_addr      (EX_LS_reg_CSR_addr),
    .EX_LS_reg_unusual_flag  (EX_LS_reg_unusual_flag),
    .EX_LS_reg_ebreak        (EX_LS_reg_ebreak),
    .EX_LS_reg_CSR_ren       (EX_LS_reg_CSR_ren),
    .EX_LS_reg_CSR_wen       (EX_LS_reg_CSR_wen),
    .EX_LS_reg_dest_wen      (EX_LS_reg_dest_wen),
    .EX_reg_execute_enable   (EX_reg_execute_enable),
    .mem_req_valid           (mem_req_valid),
    .mem_req_ready           (mem_req_ready),
    .mem_addr                (mem_addr),
    .mem_wen                 (mem_wen),
    .mem_wdata               (mem_wdata),
    .mem_wmask               (mem_wmask),
    .mem_rsp_valid           (mem_rsp_valid),
    .mem_rdata               (mem_rdata),
    .LS_WB_reg_valid         (LS_WB_reg_valid),
    .LS_WB_reg_rd            (LS_WB_reg_rd),
    .LS_WB_reg_dest_data     (LS_WB_reg_dest_data),
    .LS_WB_reg_dest_wen      (LS_WB_reg_dest_wen),
    .LS_WB_reg_csr_wdata     (LS_WB_reg_csr_wdata),
    .LS_WB_reg_csr_wfunc     (LS_WB_reg_csr_wfunc),
    .LS_WB_reg_CSR_addr      (LS_WB_reg_CSR_addr),
    .LS_WB_reg_CSR_ren       (LS_WB_reg_CSR_ren),
    .LS_WB_reg_CSR_wen       (LS_WB_reg_CSR_wen),
    .LS_WB_reg_ebreak        (LS_WB_reg_ebreak),
    .LS_WB_reg_unusual_flag  (LS_WB_reg_unusual_flag),
    .LS_WB_reg_cause         (LS_WB_reg_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned access_size(input logic [4:0] ls, input logic [3:0] ss);
    if (ls[2] || ss[2]) return 4;
    if (ls[1] || ls[4] || ss[1]) return 2;
    return 1;
  endfunction

  function automatic logic is_misaligned(input logic v, input logic [4:0] ls, input logic [3:0] ss,
                                         input logic [31:0] a);
    if (!v || (ls == 5'd0 && ss[2:0] == 3'd0)) return 1'b0;
    return (a % access_size(ls, ss)) != 0;
  endfunction

  function automatic logic wants_request(input logic v, input logic [4:0] ls, input logic [3:0] ss,
                                         input logic [31:0] a);
    return v && (ls != 5'd0 || ss[2:0] != 3'd0) && !is_misaligned(v, ls, ss, a);
  endfunction

  function automatic logic [31:0] model_load(input logic [4:0] ls, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    if (ls[0]) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    if (ls[1]) return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
    if (ls[3]) return b;
    if (ls[4]) return h;
    return rd;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] ss, input logic [31:0] d);
    if (ss[2]) return d;
    if (ss[1]) return (d & 32'hFFFF) * 32'h0001_0001;
    if (ss[0]) return (d & 32'hFF) * 32'h0101_0101;
    return d;
  endfunction

  function automatic logic [31:0] model_wmask(input logic [3:0] ss, input logic [31:0] a);
    if (ss[2]) return 32'hF;
    if (ss[1]) return 32'h3 << ((a % 4) / 2 * 2);
    if (ss[0]) return 32'h1 << (a % 4);
    return 32'h0;
  endfunction

  logic        m_pending;
  logic        m_valid, m_dest_wen, m_csr_ren, m_csr_wen, m_ebreak, m_unusual;
  logic [4:0]  m_rd;
  logic [31:0] m_dest_data, m_csr_wdata, m_cause;
  logic [1:0]  m_csr_wfunc;
  logic [11:0] m_csr_addr;
  logic        m_req_in, m_mis_in, m_req_valid, m_enable;

  assign m_req_in    = wants_request(EX_LS_reg_execute_valid, EX_LS_reg_load_sign,
                                     EX_LS_reg_store_sign, EX_LS_reg_addr_load);
  assign m_mis_in    = is_misaligned(EX_LS_reg_execute_valid, EX_LS_reg_load_sign,
                                     EX_LS_reg_store_sign, EX_LS_reg_addr_load);
  assign m_req_valid = !m_pending && m_req_in;
  assign m_enable    = (!m_pending && !m_req_in) || (m_pending && mem_rsp_valid);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_valid <= 1'b0; m_rd <= '0; m_dest_data <= '0; m_dest_wen <= 1'b0;
      m_csr_wdata <= '0; m_csr_wfunc <= '0; m_csr_addr <= '0; m_csr_ren <= 1'b0;
      m_csr_wen <= 1'b0; m_ebreak <= 1'b0; m_unusual <= 1'b0; m_cause <= '0;
    end else begin
      if (m_req_valid && mem_req_ready) m_pending <= 1'b1;
      if (m_pending && mem_rsp_valid) m_pending <= 1'b0;
      if (m_enable) begin
        m_valid     <= EX_LS_reg_execute_valid;
        m_rd        <= EX_LS_reg_rd;
        m_dest_data <= (m_pending && EX_LS_reg_load_sign != 5'd0)
                       ? model_load(EX_LS_reg_load_sign, EX_LS_reg_addr_load, mem_rdata)
                       : EX_LS_reg_dest_data;
        m_dest_wen  <= m_mis_in ? 1'b0 : EX_LS_reg_dest_wen;
        m_csr_wdata <= EX_LS_reg_csr_wdata;
        m_csr_wfunc <= EX_LS_reg_csr_wfunc;
        m_csr_addr  <= EX_LS_reg_CSR_addr;
        m_csr_ren   <= EX_LS_reg_CSR_ren;
        m_csr_wen   <= EX_LS_reg_CSR_wen;
        m_ebreak    <= EX_LS_reg_ebreak;
        m_unusual   <= m_mis_in ? 1'b1 : EX_LS_reg_unusual_flag;
        m_cause     <= m_mis_in ? ((EX_LS_reg_load_sign != 5'd0) ? 32'd4 : 32'd6)
                                : EX_LS_reg_cause;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("wb_valid",     32'(LS_WB_reg_valid),        32'(m_valid));
    checkOutput("wb_rd",        32'(LS_WB_reg_rd),           32'(m_rd));
    checkOutput("wb_dest_data", LS_WB_reg_dest_data,         m_dest_data);
    checkOutput("wb_dest_wen",  32'(LS_WB_reg_dest_wen),     32'(m_dest_wen));
    checkOutput("wb_csr_wdata", LS_WB_reg_csr_wdata,         m_csr_wdata);
    checkOutput("wb_csr_wfunc", 32'(LS_WB_reg_csr_wfunc),    32'(m_csr_wfunc));
    checkOutput("wb_csr_addr",  32'(LS_WB_reg_CSR_addr),     32'(m_csr_addr));
    checkOutput("wb_csr_ren",   32'(LS_WB_reg_CSR_ren),      32'(m_csr_ren));
    checkOutput("wb_csr_wen",   32'(LS_WB_reg_CSR_wen),      32'(m_csr_wen));
    checkOutput("wb_ebreak",    32'(LS_WB_reg_ebreak),       32'(m_ebreak));
    checkOutput("wb_unusual",   32'(LS_WB_reg_unusual_flag), 32'(m_unusual));
    checkOutput("wb_cause",     LS_WB_reg_cause,             m_cause);
    checkOutput("ex_enable",    32'(EX_reg_execute_enable),  32'(m_enable));
    checkOutput("req_valid",    32'(mem_req_valid),          32'(m_req_valid));
    if (m_req_valid) begin
      checkOutput("req_addr",  mem_addr, EX_LS_reg_addr_load & 32'hFFFF_FFFC);
      checkOutput("req_wen",   32'(mem_wen), 32'(EX_LS_reg_store_sign[2:0] != 3'd0));
      if (EX_LS_reg_store_sign[2:0] != 3'd0) begin
        checkOutput("req_wdata", mem_wdata, model_wdata(EX_LS_reg_store_sign, EX_LS_reg_store_data));
      end
      checkOutput("req_wmask", 32'(mem_wmask), model_wmask(EX_LS_reg_store_sign, EX_LS_reg_addr_load));
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic v, input logic [4:0] ls, input logic [3:0] ss,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] ddata, input logic [4:0] rd,
                               input int ready_wait, input int rsp_wait, input logic [31:0] rdata,
                               input logic [31:0] lit_addr, input logic [31:0] lit_wdata,
                               input logic [31:0] lit_wmask);
    EX_LS_reg_execute_valid = v;
    EX_LS_reg_load_sign     = ls;
    EX_LS_reg_store_sign    = ss;
    EX_LS_reg_addr_load     = addr;
    EX_LS_reg_store_data    = sdata;
    EX_LS_reg_dest_data     = ddata;
    EX_LS_reg_rd            = rd;
    EX_LS_reg_dest_wen      = 1'b1;
    EX_LS_reg_csr_wdata     = ddata ^ 32'h5A5A_0F0F;
    EX_LS_reg_cause         = {27'd0, rd};
    EX_LS_reg_csr_wfunc     = rd[1:0];
    EX_LS_reg_CSR_addr      = {7'd0, rd};
    EX_LS_reg_unusual_flag  = 1'b0;
    EX_LS_reg_ebreak        = rd[0];
    EX_LS_reg_CSR_ren       = rd[1];
    EX_LS_reg_CSR_wen       = rd[2];
    mem_rdata               = 32'h0;
    if (!wants_request(v, ls, ss, addr)) begin
      @(posedge clk); #2;
      return;
    end
    #1;
    checkOutput("lit_req_addr", mem_addr, lit_addr);
    if (ss[2:0] != 3'd0) begin
      checkOutput("lit_req_wdata", mem_wdata, lit_wdata);
      checkOutput("lit_req_wmask", 32'(mem_wmask), lit_wmask);
    end
    mem_req_ready = 1'b0;
    repeat (ready_wait) begin @(posedge clk); #2; end
    mem_req_ready = 1'b1;
    @(posedge clk); #2;
    mem_req_ready = 1'b0;
    repeat (rsp_wait) begin @(posedge clk); #2; end
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    @(posedge clk); #2;
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    EX_LS_reg_execute_valid = 1'b0; EX_LS_reg_dest_data = '0; EX_LS_reg_addr_load = '0;
    EX_LS_reg_store_data = '0; EX_LS_reg_rd = '0; EX_LS_reg_load_sign = '0;
    EX_LS_reg_store_sign = '0; EX_LS_reg_csr_wdata = '0; EX_LS_reg_cause = '0;
    EX_LS_reg_csr_wfunc = '0; EX_LS_reg_CSR_addr = '0; EX_LS_reg_unusual_flag = 1'b0;
    EX_LS_reg_ebreak = 1'b0; EX_LS_reg_CSR_ren = 1'b0; EX_LS_reg_CSR_wen = 1'b0;
    EX_LS_reg_dest_wen = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("lit_reset_valid", 32'(LS_WB_reg_valid), 32'h0);
    checkOutput("lit_reset_cause", LS_WB_reg_cause, 32'h0);
    checkOutput("lit_reset_enable", 32'(EX_reg_execute_enable), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    $display("[TB] non-memory entry");
    applyStimulus(1'b1, 5'd0, 4'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_alu_valid", 32'(LS_WB_reg_valid), 32'h1);
    checkOutput("lit_alu_data", LS_WB_reg_dest_data, 32'h0000_1234);
    checkOutput("lit_alu_rd", 32'(LS_WB_reg_rd), 32'd5);
    checkOutput("lit_alu_enable", 32'(EX_reg_execute_enable), 32'h1);

    $display("[TB] lb / lbu");
    applyStimulus(1'b1, 5'b00001, 4'd0, 32'h8000_0003, 32'h0, 32'h0, 5'd6, 0, 0, 32'h80FF_0000,
                  32'h8000_0000, 0, 0);
    checkOutput("lit_lb_data", LS_WB_reg_dest_data, 32'hFFFF_FF80);
    applyStimulus(1'b1, 5'b01000, 4'd0, 32'h8000_0003, 32'h0, 32'h0, 5'd7, 0, 0, 32'h80FF_0000,
                  32'h8000_0000, 0, 0);
    checkOutput("lit_lbu_data", LS_WB_reg_dest_data, 32'h0000_0080);

    $display("[TB] sh with ready stall");
    applyStimulus(1'b1, 5'd0, 4'b0010, 32'h8000_0002, 32'hABCD_1234, 32'h77, 5'd8, 3, 0,
                  32'hDEAD_DEAD, 32'h8000_0000, 32'h1234_1234, 32'hC);
    checkOutput("lit_sh_data", LS_WB_reg_dest_data, 32'h0000_0077);

    $display("[TB] misaligned lw / sw");
    applyStimulus(1'b1, 5'b00100, 4'd0, 32'h8000_0001, 32'h0, 32'h99, 5'd9, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_lw_mis_flag", 32'(LS_WB_reg_unusual_flag), 32'h1);
    checkOutput("lit_lw_mis_cause", LS_WB_reg_cause, 32'd4);
    checkOutput("lit_lw_mis_wen", 32'(LS_WB_reg_dest_wen), 32'h0);
    applyStimulus(1'b1, 5'd0, 4'b0100, 32'h0000_0006, 32'h1, 32'h0, 5'd10, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_sw_mis_cause", LS_WB_reg_cause, 32'd6);

    $display("[TB] lhu with delayed response");
    applyStimulus(1'b1, 5'b10000, 4'd0, 32'h0000_0002, 32'h0, 32'h0, 5'd11, 0, 5, 32'hF00D_0000,
                  32'h0, 0, 0);
    checkOutput("lit_lhu_data", LS_WB_reg_dest_data, 32'h0000_F00D);
    checkOutput("lit_lhu_idle_reissue", 32'(mem_req_valid), 32'h1);

    $display("[TB] lh / lw / sb / sw / flush");
    applyStimulus(1'b1, 5'b00010, 4'd0, 32'h0000_0010, 32'h0, 32'h0, 5'd12, 1, 2, 32'h0000_8001,
                  32'h10, 0, 0);
    checkOutput("lit_lh_data", LS_WB_reg_dest_data, 32'hFFFF_8001);
    applyStimulus(1'b1, 5'b00100, 4'd0, 32'h0000_0020, 32'h0, 32'h0, 5'd13, 0, 1, 32'hDEAD_BEEF,
                  32'h20, 0, 0);
    checkOutput("lit_lw_data", LS_WB_reg_dest_data, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 5'd0, 4'b0001, 32'h0000_0031, 32'h0000_005A, 32'h3, 5'd14, 0, 0,
                  32'h1111_1111, 32'h30, 32'h5A5A_5A5A, 32'h2);
    applyStimulus(1'b1, 5'd0, 4'b0100, 32'h0000_0040, 32'hCAFE_F00D, 32'h4, 5'd15, 2, 0,
                  32'h0, 32'h40, 32'hCAFE_F00D, 32'hF);
    applyStimulus(1'b0, 5'b00100, 4'd0, 32'h0000_0050, 32'h0, 32'h0, 5'd16, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_flush_valid", 32'(LS_WB_reg_valid), 32'h0);

    $display("[TB] reset during outstanding load");
    applyStimulus(1'b1, 5'd0, 4'd0, 32'h0, 32'h0, 32'h55, 5'd17, 0, 0, 32'h0, 0, 0, 0);
    EX_LS_reg_execute_valid = 1'b1;
    EX_LS_reg_load_sign     = 5'b10000;
    EX_LS_reg_store_sign    = 4'd0;
    EX_LS_reg_addr_load     = 32'h0000_0004;
    mem_req_ready = 1'b1;
    @(posedge clk); #2;
    mem_req_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("lit_rst_wb_valid", 32'(LS_WB_reg_valid), 32'h0);
    checkOutput("lit_rst_wb_data", LS_WB_reg_dest_data, 32'h0);
    checkOutput("lit_rst_idle_req", 32'(mem_req_valid), 32'h1);
    EX_LS_reg_execute_valid = 1'b0;
    EX_LS_reg_load_sign     = 5'd0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hBAD0_BAD0;
    @(posedge clk); #2;
    mem_rsp_valid = 1'b0;
    checkOutput("lit_stray_rsp_valid", 32'(LS_WB_reg_valid), 32'h0);
    repeat (2) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
